adder_8_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one adder_8 datapath (7-bit input bundle, 4-bit result) among NREQ requesters.
- Datapath instance (exact or BLASYS-approximated variant) sits outside the block and connects through dp_in/dp_out, so variants swap without touching control.
- Two-stage pipeline: operand register, then result register. Valid/ready handshake on both the request side and the response side. Throughput one op per cycle.

---
 rtl/adder_8_share_arb.sv | 105 ++++++++++
 tb/tb_adder_8_share_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_8_share_arb.sv
// Round-robin arbiter feeding one shared adder_8 datapath through a two-stage
// pipeline: operand register (drives dp_in), then result register (rsp_*).
module adder_8_share_arb #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 7,
  parameter int OUT_W = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IN_W-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [IN_W-1:0]        dp_in,
  input  logic [OUT_W-1:0]       dp_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OUT_W-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       txn_count,
  output logic                   idle
);

  // Handshake: a transfer happens on a cycle where valid and ready are both 1.
  // req_valid/req_data are held by the requester until its req_ready bit is seen;
  // rsp_data/rsp_id are held stable while rsp_valid=1 and rsp_ready=0.

  logic            op_valid;
  logic [IN_W-1:0] op_data;
  logic [ID_W-1:0] op_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] rr_next;
  logic            gnt_found;
  logic            grant;
  logic            rsp_adv;
  logic            issue_ok;
  logic [IN_W-1:0] op_next;
  int              idx;

  assign rsp_adv  = op_valid & (~rsp_valid | rsp_ready);
  assign issue_ok = en & ~rst & (~op_valid | rsp_adv);
  assign grant    = issue_ok & gnt_found;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign rr_next = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign op_next = req_data[gnt_idx*IN_W +: IN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op_data   <= '0;
      op_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      txn_count <= '0;
    end else begin
      if (grant) begin
        op_data  <= op_next;
        op_id    <= gnt_idx;
        op_valid <= 1'b1;
        rr_ptr   <= rr_next;
      end else if (rsp_adv) begin
        // The op moved to the result stage and nothing replaced it (also while draining).
        op_valid <= 1'b0;
      end

      if (rsp_adv) begin
        rsp_data  <= dp_out;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (rsp_valid && rsp_ready) txn_count <= txn_count + 1'b1;
    end
  end

  assign dp_in = op_data;
  assign idle  = ~op_valid & ~rsp_valid;

endmodule

// File: tb/tb_adder_8_share_arb.sv
// Bench for adder_8_share_arb: randomized requesters, a round-robin/occupancy
// reference model, and a scoreboard monitor checking every response in order.
module tb_adder_8_share_arb;

  localparam int NREQ  = 4;
  localparam int IN_W  = 7;
  localparam int OUT_W = 4;
  localparam int CNT_W = 16;
  localparam int ID_W  = 2;
  localparam int SBW   = ID_W + OUT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      dp_in;
  logic [OUT_W-1:0]     dp_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [CNT_W-1:0]     txn_count;
  logic                 idle;

  adder_8_share_arb #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dp_in(dp_in), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .txn_count(txn_count), .idle(idle)
  );

  // Datapath stub: result is the low nibble of the operand bundle.
  assign dp_out = dp_in[OUT_W-1:0];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [SBW-1:0]  exp_q[$];          // expected {id, result}, in response order
  int              age_q[$];          // clock edges since each in-flight op was accepted
  logic [IN_W-1:0] pend [NREQ][$];    // each requester's queued operands
  int              m_rr = 0;
  logic [CNT_W-1:0] m_txn = '0;
  logic [NREQ-1:0] last_ready;

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (pend[i].size() > 0);
      req_data[i*IN_W +: IN_W] = (pend[i].size() > 0) ? pend[i][0] : IN_W'($urandom);
    end
  endtask

  // One clock cycle: drive, predict and check at negedge, advance model, return at posedge+1.
  task automatic step();
    bit              vis;
    bit              issue;
    int              g;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic [IN_W-1:0] d;
    logic [31:0]     gv;
    drive();
    @(negedge clk);
    vis = (age_q.size() > 0) && (age_q[0] >= 1);
    check("rsp_valid", rsp_valid, vis);
    check("idle", idle, age_q.size() == 0);
    check("txn_count", txn_count, m_txn);
    // Two ops fit in flight; a third may enter only if one leaves this cycle.
    issue = en && ((age_q.size() < 2) || rsp_ready);
    g = -1;
    if (issue) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (g < 0 && pend[idx].size() > 0) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    last_ready = req_ready;

    if (vis && rsp_ready) begin
      void'(age_q.pop_front());
      m_txn = m_txn + 1'b1;
    end
    foreach (age_q[i]) age_q[i]++;
    if (g >= 0) begin
      d  = pend[g][0];
      gv = g;
      age_q.push_back(0);
      exp_q.push_back({gv[ID_W-1:0], 4'(d % 16)});
      m_rr = (g + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst) begin
      exp_q.delete();
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = exp_q[0];
        check("rsp_id", rsp_id, e[SBW-1:OUT_W]);
        check("rsp_data", rsp_data, e[OUT_W-1:0]);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] t0;
    bit wrapped;
    rst = 1'b1;
    en = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_data = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_dp_in", dp_in, 0);
    check("rst_txn", txn_count, 0);
    check("rst_idle", idle, 1);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Single op from requester 2
    pend[2].push_back(7'h55);
    step();
    check("single_grant", last_ready, 4'b0100);
    check("single_dp_in", dp_in, 7'h55);
    step();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_data", rsp_data, 4'h5);
    check("single_rsp_id", rsp_id, 2);
    step();
    check("single_txn", txn_count, 1);

    // Backpressure with two ops queued
    rsp_ready = 1'b0;
    pend[0].push_back(7'h2A);
    pend[1].push_back(7'h3B);
    t0 = txn_count;
    repeat (5) step();
    check("bp_full_ready", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (3) step();
    check("bp_txn_plus2", txn_count, 32'(t0 + 2'd2));

    // Drain: en falls with the pipeline full
    rsp_ready = 1'b0;
    pend[1].push_back(7'h11);
    pend[2].push_back(7'h22);
    pend[3].push_back(7'h33);
    repeat (3) step();
    en = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step();
    check("drain_idle", idle, 1);
    check("drain_no_grant", req_ready, 0);
    en = 1'b1;
    repeat (3) step();

    // Reset mid-op with both stages full
    rsp_ready = 1'b0;
    pend[0].push_back(7'h0F);
    pend[1].push_back(7'h1E);
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_dp_in", dp_in, 0);
    check("mid_rst_txn", txn_count, 0);
    age_q.delete();
    m_rr = 0;
    m_txn = '0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;

    // Fairness: all requesters held valid, pointer restarted at 0
    for (int i = 0; i < NREQ; i++) begin
      pend[i].push_back(IN_W'(i + 1));
      pend[i].push_back(IN_W'(i + 5));
    end
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_grant", last_ready, 32'(1 << (k % NREQ)));
    end
    repeat (3) step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 1) == 1 && pend[i].size() < 3)
          pend[i].push_back(IN_W'($urandom_range(0, 127)));
      step();
    end
    en = 1'b1;
    rsp_ready = 1'b1;
    repeat (20) step();
    check("sb_empty_mid", exp_q.size(), 0);

    // Counter wrap via streamed responses
    wrapped = 1'b0;
    for (int n = 0; n < 70000 && !wrapped; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (pend[i].size() < 2) pend[i].push_back(IN_W'($urandom_range(0, 127)));
      if (txn_count == 16'hFFFF) begin
        step();
        check("txn_wrap", txn_count, 16'h0000);
        wrapped = 1'b1;
      end else begin
        step();
      end
    end
    check("wrap_seen", wrapped, 1);
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    repeat (5) step();
    check("sb_empty_end", exp_q.size(), 0);
    check("end_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
